// File: rtl/inst_fetch.sv
// Instruction fetch/issue sequencer: fetches 16-bit words over a REQ/ACK
// handshake, issues them to the decoder and advances the PC on accept.
module inst_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [15:0]     i_imem_data,
  output logic [15:0]     o_inst,
  output logic            o_inst_valid,
  input  logic            i_stall,
  input  logic            i_bs,
  input  logic [5:0]      i_off,
  input  logic            i_halt,
  output logic [PC_W-1:0] o_pc,
  output logic            o_halted,
  output logic [15:0]     o_retired
);

  typedef enum logic [1:0] {
    S_START,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [15:0]     r_inst;
  logic [15:0]     w_inst_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            r_req;
  logic            w_req_nxt;
  logic            r_halted;
  logic            w_halted_nxt;
  logic [15:0]     r_retired;
  logic [15:0]     w_retired_nxt;

  logic [PC_W-1:0] w_off_ext;
  logic [PC_W-1:0] w_pc_seq;
  logic [PC_W-1:0] w_pc_br;
  logic [15:0]     w_retired_inc;

  // Branch target is relative to the instruction after the current one.
  assign w_off_ext     = PC_W'($signed(i_off));
  assign w_pc_seq      = r_pc + PC_W'(1);
  assign w_pc_br       = w_pc_seq + w_off_ext;
  assign w_retired_inc = (r_retired == 16'hFFFF) ? r_retired : r_retired + 16'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_START;
      r_pc      <= RESET_PC;
      r_inst    <= 16'h0000;
      r_valid   <= 1'b0;
      r_req     <= 1'b0;
      r_halted  <= 1'b0;
      r_retired <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_inst    <= w_inst_nxt;
      r_valid   <= w_valid_nxt;
      r_req     <= w_req_nxt;
      r_halted  <= w_halted_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  // Outputs are registered, so each one is computed for the state being entered.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_inst_nxt    = r_inst;
    w_valid_nxt   = r_valid;
    w_req_nxt     = r_req;
    w_halted_nxt  = r_halted;
    w_retired_nxt = r_retired;

    case (r_state)
      S_START: begin
        w_state_nxt = S_FETCH;
        w_req_nxt   = 1'b1;
      end

      S_FETCH: begin
        if (i_imem_ack) begin
          w_inst_nxt  = i_imem_data;
          w_valid_nxt = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!i_stall) begin
          w_retired_nxt = w_retired_inc;
          w_valid_nxt   = 1'b0;
          if (i_halt) begin
            w_state_nxt  = S_HALT;
            w_halted_nxt = 1'b1;
            w_inst_nxt   = 16'h0000;
          end else if (i_bs) begin
            w_pc_nxt    = w_pc_br;
            w_req_nxt   = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_pc_nxt    = w_pc_seq;
            w_req_nxt   = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end

      S_HALT: begin
        w_req_nxt    = 1'b0;
        w_valid_nxt  = 1'b0;
        w_inst_nxt   = 16'h0000;
        w_halted_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = S_START;
      end
    endcase
  end

  assign o_imem_req   = r_req;
  assign o_imem_addr  = r_pc;
  assign o_inst       = r_inst;
  assign o_inst_valid = r_valid;
  assign o_pc         = r_pc;
  assign o_halted     = r_halted;
  assign o_retired    = r_retired;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a per-cycle vector table plus a branch
// sequence that walks the PC across the 8-bit wrap boundary.
module tb_inst_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [7:0]  o_imem_addr;
  logic        i_imem_ack;
  logic [15:0] i_imem_data;
  logic [15:0] o_inst;
  logic        o_inst_valid;
  logic        i_stall;
  logic        i_bs;
  logic [5:0]  i_off;
  logic        i_halt;
  logic [7:0]  o_pc;
  logic        o_halted;
  logic [15:0] o_retired;

  always #5 i_clk = ~i_clk;

  inst_fetch #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_data  (i_imem_data),
    .o_inst       (o_inst),
    .o_inst_valid (o_inst_valid),
    .i_stall      (i_stall),
    .i_bs         (i_bs),
    .i_off        (i_off),
    .i_halt       (i_halt),
    .o_pc         (o_pc),
    .o_halted     (o_halted),
    .o_retired    (o_retired)
  );

  typedef struct {
    logic        rstN;
    logic        ack;
    logic [15:0] data;
    logic        stall;
    logic        bs;
    logic [5:0]  off;
    logic        halt;
    logic        eReq;
    logic [7:0]  ePc;
    logic [15:0] eInst;
    logic        eValid;
    logic        eHalted;
    logic [15:0] eRet;
  } vec_t;

  typedef struct {
    logic       bs;
    logic [5:0] off;
    logic [7:0] ePc;
  } br_t;

  vec_t        vecs [34];
  br_t         brs  [11];
  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] expRetired;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    i_rst_n     = v.rstN;
    i_imem_ack  = v.ack;
    i_imem_data = v.data;
    i_stall     = v.stall;
    i_bs        = v.bs;
    i_off       = v.off;
    i_halt      = v.halt;
    @(posedge i_clk);
    #1;
    checkOutput($sformatf("v%0d req", idx),     16'(o_imem_req),   16'(v.eReq));
    checkOutput($sformatf("v%0d addr", idx),    16'(o_imem_addr),  16'(v.ePc));
    checkOutput($sformatf("v%0d pc", idx),      16'(o_pc),         16'(v.ePc));
    checkOutput($sformatf("v%0d inst", idx),    o_inst,            v.eInst);
    checkOutput($sformatf("v%0d valid", idx),   16'(o_inst_valid), 16'(v.eValid));
    checkOutput($sformatf("v%0d halted", idx),  16'(o_halted),     16'(v.eHalted));
    checkOutput($sformatf("v%0d retired", idx), o_retired,         v.eRet);
  endtask

  // One zero-wait fetch followed by an immediate accept with the given branch.
  task automatic stepInst(input int k, input logic bs, input logic [5:0] off, input logic [7:0] ePc);
    i_imem_ack  = 1'b1;
    i_imem_data = 16'h2000 + 16'(k);
    i_stall     = 1'b0;
    i_bs        = 1'b0;
    i_halt      = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput($sformatf("br%0d inst", k),  o_inst, 16'h2000 + 16'(k));
    checkOutput($sformatf("br%0d valid", k), 16'(o_inst_valid), 16'h0001);
    i_imem_ack = 1'b0;
    i_bs       = bs;
    i_off      = off;
    @(posedge i_clk);
    #1;
    expRetired = expRetired + 16'd1;
    checkOutput($sformatf("br%0d pc", k),      16'(o_pc),        16'(ePc));
    checkOutput($sformatf("br%0d addr", k),    16'(o_imem_addr), 16'(ePc));
    checkOutput($sformatf("br%0d req", k),     16'(o_imem_req),  16'h0001);
    checkOutput($sformatf("br%0d retired", k), o_retired,        expRetired);
    i_bs  = 1'b0;
    i_off = 6'h00;
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_imem_ack  = 1'b0;
    i_imem_data = 16'h0000;
    i_stall     = 1'b0;
    i_bs        = 1'b0;
    i_off       = 6'h00;
    i_halt      = 1'b0;

    //            rst  ack  data      stl  bs   off    hlt  | req  pc     inst      vld  hlt  ret
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 16'hABCD, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h00, 16'h1000, 1'b1, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 8'h01, 16'h1000, 1'b0, 1'b0, 16'd1};
    vecs[5]  = '{1'b1, 1'b1, 16'h1001, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h01, 16'h1001, 1'b1, 1'b0, 16'd1};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 8'h02, 16'h1001, 1'b0, 1'b0, 16'd2};
    vecs[7]  = '{1'b1, 1'b1, 16'h1002, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h02, 16'h1002, 1'b1, 1'b0, 16'd2};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 8'h03, 16'h1002, 1'b0, 1'b0, 16'd3};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 8'h03, 16'h1002, 1'b0, 1'b0, 16'd3};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 8'h03, 16'h1002, 1'b0, 1'b0, 16'd3};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 8'h03, 16'h1002, 1'b0, 1'b0, 16'd3};
    vecs[12] = '{1'b1, 1'b1, 16'h1003, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h03, 16'h1003, 1'b1, 1'b0, 16'd3};
    vecs[13] = '{1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 8'h03, 16'h1003, 1'b1, 1'b0, 16'd3};
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 8'h04, 16'h1003, 1'b0, 1'b0, 16'd4};
    vecs[15] = '{1'b1, 1'b1, 16'h1004, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h04, 16'h1004, 1'b1, 1'b0, 16'd4};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 8'h05, 16'h1004, 1'b0, 1'b0, 16'd5};
    vecs[17] = '{1'b1, 1'b1, 16'h1005, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h05, 16'h1005, 1'b1, 1'b0, 16'd5};
    vecs[18] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 6'h3D, 1'b0, 1'b1, 8'h03, 16'h1005, 1'b0, 1'b0, 16'd6};
    vecs[19] = '{1'b1, 1'b1, 16'h1003, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h03, 16'h1003, 1'b1, 1'b0, 16'd6};
    vecs[20] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 6'h10, 1'b0, 1'b0, 8'h03, 16'h1003, 1'b1, 1'b0, 16'd6};
    vecs[21] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 8'h03, 16'h1003, 1'b1, 1'b0, 16'd6};
    vecs[22] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 6'h3F, 1'b1, 1'b0, 8'h03, 16'h1003, 1'b1, 1'b0, 16'd6};
    vecs[23] = '{1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 8'h03, 16'h1003, 1'b1, 1'b0, 16'd6};
    vecs[24] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 6'h02, 1'b0, 1'b1, 8'h06, 16'h1003, 1'b0, 1'b0, 16'd7};
    vecs[25] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 6'h05, 1'b1, 1'b1, 8'h06, 16'h1003, 1'b0, 1'b0, 16'd7};
    vecs[26] = '{1'b1, 1'b1, 16'h1006, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h06, 16'h1006, 1'b1, 1'b0, 16'd7};
    vecs[27] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 6'h05, 1'b1, 1'b0, 8'h06, 16'h0000, 1'b0, 1'b1, 16'd8};
    vecs[28] = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h06, 16'h0000, 1'b0, 1'b1, 16'd8};
    vecs[29] = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 6'h01, 1'b0, 1'b0, 8'h06, 16'h0000, 1'b0, 1'b1, 16'd8};
    vecs[30] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'd0};
    vecs[31] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 16'd0};
    vecs[32] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 16'd0};
    vecs[33] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'd0};

    // PC walk: seven +31 hops to E0, then to FE, across the top to 03,
    // backwards below zero to FF, and a sequential step from FF to 00.
    brs[0]  = '{1'b1, 6'h1F, 8'h20};
    brs[1]  = '{1'b1, 6'h1F, 8'h40};
    brs[2]  = '{1'b1, 6'h1F, 8'h60};
    brs[3]  = '{1'b1, 6'h1F, 8'h80};
    brs[4]  = '{1'b1, 6'h1F, 8'hA0};
    brs[5]  = '{1'b1, 6'h1F, 8'hC0};
    brs[6]  = '{1'b1, 6'h1F, 8'hE0};
    brs[7]  = '{1'b1, 6'h1D, 8'hFE};
    brs[8]  = '{1'b1, 6'h04, 8'h03};
    brs[9]  = '{1'b1, 6'h3B, 8'hFF};
    brs[10] = '{1'b0, 6'h00, 8'h00};

    for (int i = 0; i < 34; i++) begin
      applyStimulus(i);
    end

    i_rst_n    = 1'b1;
    i_imem_ack = 1'b0;
    i_bs       = 1'b0;
    i_halt     = 1'b0;
    i_stall    = 1'b0;
    expRetired = 16'd0;
    @(posedge i_clk);
    #1;
    checkOutput("walk start req", 16'(o_imem_req), 16'h0001);
    checkOutput("walk start pc",  16'(o_pc),       16'h0000);

    for (int k = 0; k < 11; k++) begin
      stepInst(k, brs[k].bs, brs[k].off, brs[k].ePc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch/issue sequencer: the producer side of the 16-bit INST bus consumed by the instruction decoder.
- Holds the PC and requests words from instruction memory over a REQ/ACK handshake.
- Presents each word on INST with INST_VALID and advances the PC, sequentially or by branch offset.
- Stops permanently on HALT; sits between instruction memory and the decoder/datapath.

Parameters:
- PC_W, 8: PC and instruction-memory address width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  synchronous active-low reset.
- IMEM_REQ  out  1  fetch request to instruction memory.
- IMEM_ADDR  out  PC_W  fetch address; always equals PC.
- IMEM_ACK  in  1  memory returns IMEM_DATA this cycle.
- IMEM_DATA  in  16  instruction word; valid when IMEM_ACK=1.
- INST  out  16  instruction to decoder (registered).
- INST_VALID  out  1  INST holds a live instruction awaiting acceptance.
- STALL  in  1  datapath not ready; INST is held while STALL=1.
- BS  in  1  branch taken for the current INST; sampled at accept.
- OFF  in  6  signed branch offset (two's complement); sampled at accept.
- HALT  in  1  current INST is a halt; sampled at accept.
- PC  out  PC_W  address of the current/next instruction.
- HALTED  out  1  sequencer has stopped.
- RETIRED  out  16  count of accepted instructions.

Behaviour:
- Reset (RST_N=0 at an edge), from any state, including mid-fetch or mid-issue:
  - State=S_START, PC=RESET_PC, INST=16'h0000.
  - INST_VALID=0, IMEM_REQ=0, HALTED=0, RETIRED=0.
- All outputs are registered except IMEM_ADDR, which is wired to PC.
- State machine:
  - S_START: IMEM_REQ=0. Go to S_FETCH next cycle, so the first request appears 1 cycle after reset release.
  - S_FETCH: IMEM_REQ=1 and IMEM_ADDR=PC, both held stable until ACK.
    - On IMEM_ACK=1: INST<=IMEM_DATA, INST_VALID<=1, IMEM_REQ<=0, go to S_ISSUE.
    - IMEM_ACK may arrive in the first FETCH cycle (zero wait states).
  - S_ISSUE: INST and INST_VALID held.
    - "Accept" = the S_ISSUE cycle with STALL=0.
    - On accept: RETIRED<=RETIRED+1, saturating at 16'hFFFF; INST_VALID<=0.
    - If HALT=1: go to S_HALT, HALTED<=1, PC unchanged.
    - Else if BS=1: PC<=PC+1+sext(OFF), go to S_FETCH.
    - Else: PC<=PC+1, go to S_FETCH.
    - While STALL=1: no change.
  - S_HALT: terminal until reset.
    - IMEM_REQ=0, INST_VALID=0, INST<=16'h0000 (no-write opcode), HALTED=1.
- Priority at accept: HALT > BS > sequential.
  - BS, OFF and HALT are ignored outside the accept cycle.
- IMEM_ACK outside S_FETCH is ignored; INST is not updated.
- PC arithmetic is modulo 2^PC_W; sext(OFF) is extended to PC_W bits.
  - PC=2^PC_W-1 sequential -> 0.
  - Negative offsets wrap below 0.
- Throughput: best case 1 instruction per 2 cycles (FETCH+ACK, then ISSUE accept).
  - Each memory wait cycle adds 1; each STALL cycle adds 1.
- INST_VALID rises the cycle after ACK and falls the cycle after accept.

Test Plan:
- Reset, zero-wait memory returning mem[a]=16'h1000+a, STALL=0, BS=0:
  - IMEM_REQ first high 1 cycle after reset release.
  - INST sequence 1000,1001,1002 on INST_VALID cycles 2 apart.
  - PC 0,1,2; RETIRED increments per accept.
- Memory with ACK delayed 3 cycles:
  - IMEM_REQ and IMEM_ADDR stable all 3 cycles.
  - INST_VALID rises exactly 1 cycle after ACK.
  - A spurious ACK during S_ISSUE leaves INST unchanged.
- At PC=5, accept with BS=1, OFF=6'b111101 (-3) -> next IMEM_ADDR=3.
  - At PC=8'hFE, BS=1, OFF=+4 -> next IMEM_ADDR=8'h03.
  - PC=8'hFF sequential -> 8'h00.
- STALL=1 for 4 cycles in S_ISSUE with BS/HALT toggling:
  - INST and INST_VALID held, PC and RETIRED unchanged.
  - Values present at the STALL=0 cycle decide the next PC.
- Accept with HALT=1 and BS=1 together:
  - HALTED=1 next cycle, PC unchanged, INST=0000, IMEM_REQ=0 forever.
  - RST_N=0 for one edge restarts fetch at RESET_PC.
- Assert RST_N=0 while in S_FETCH waiting on ACK:
  - Next cycle IMEM_REQ=0, PC=RESET_PC, INST_VALID=0, RETIRED=0.
